// File: rtl/riscv_mc_pkg.sv
// riscv_mc_pkg: shared opcodes, controller states and mux/ALU encodings for the multicycle RV32I core
package riscv_mc_pkg;
  localparam int STATE_W = 4;
  localparam int ALUCTRL_W = 3;
  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;
  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  typedef enum logic [STATE_W-1:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL
  } state_e;
  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_SUB = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [ALUCTRL_W-1:0] ALU_ADD = 3'b000;
  localparam logic [ALUCTRL_W-1:0] ALU_SUB = 3'b001;
  localparam logic [ALUCTRL_W-1:0] ALU_AND = 3'b010;
  localparam logic [ALUCTRL_W-1:0] ALU_OR = 3'b011;
  localparam logic [ALUCTRL_W-1:0] ALU_SLT = 3'b101;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA = 2'b01;
  localparam logic [1:0] RES_ALU = 2'b10;
  localparam logic [1:0] SRCA_PC = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1 = 2'b10;
  localparam logic [1:0] SRCB_RS2 = 2'b00;
  localparam logic [1:0] SRCB_IMM = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;
endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: maps the controller's alu_op and instruction funct fields to the ALU operation select
module alu_decoder
  import riscv_mc_pkg::*;
(
  input  logic [1:0]           alu_op,
  input  logic [2:0]           funct3,
  input  logic                 op5,
  input  logic                 funct7b5,
  output logic [ALUCTRL_W-1:0] alu_control
);
  logic [ALUCTRL_W-1:0] funct_ctrl;
  // sub only for R-type with funct7b5 set; addi shares funct3 000 but must stay an add
  always_comb begin
    funct_ctrl = funct3 == 3'b000 ? ((op5 & funct7b5) ? ALU_SUB : ALU_ADD) :
                 funct3 == 3'b010 ? ALU_SLT :
                 funct3 == 3'b110 ? ALU_OR :
                 funct3 == 3'b111 ? ALU_AND : ALU_ADD;
    alu_control = alu_op == ALUOP_SUB ? ALU_SUB : alu_op == ALUOP_FUNCT ? funct_ctrl : ALU_ADD;
  end
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore FSM sequencing the shared multicycle RV32I datapath
module multicycle_controller
  import riscv_mc_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           op,
  input  logic [2:0]           funct3,
  input  logic                 funct7b5,
  input  logic                 zero,
  output logic                 pc_write,
  output logic                 adr_src,
  output logic                 mem_write,
  output logic                 ir_write,
  output logic [1:0]           result_src,
  output logic [1:0]           alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [ALUCTRL_W-1:0] alu_control,
  output logic [1:0]           imm_src,
  output logic                 reg_write,
  output logic                 illegal_op
);
  state_e state_q, state_d, cur;
  logic [1:0] alu_op;
  logic pc_update, branch, ir_w, mem_w, reg_w, legal;
  assign legal = op == OP_LW || op == OP_SW || op == OP_R || op == OP_I || op == OP_BEQ || op == OP_JAL;
  // while reset is held the outputs look like FETCH so the datapath sees a quiet, known setting
  assign cur = reset ? S_FETCH : state_q;
  // next-state selection; unused encodings fall back to FETCH
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = (op == OP_LW || op == OP_SW) ? S_MEMADR :
                          op == OP_R ? S_EXECR : op == OP_I ? S_EXECI :
                          op == OP_BEQ ? S_BEQ : op == OP_JAL ? S_JAL : S_FETCH;
      S_MEMADR: state_d = op == OP_LW ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD: state_d = S_MEMWB;
      S_EXECR, S_EXECI, S_JAL: state_d = S_ALUWB;
      default: state_d = S_FETCH;
    endcase
  end
  // state register with synchronous reset to FETCH
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else state_q <= state_d;
  end
  // per-state mux selects and raw write enables
  always_comb begin
    adr_src = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_a = SRCA_PC;
    alu_src_b = SRCB_RS2;
    alu_op = ALUOP_ADD;
    ir_w = 1'b0;
    mem_w = 1'b0;
    reg_w = 1'b0;
    pc_update = 1'b0;
    branch = 1'b0;
    case (cur)
      S_FETCH: begin ir_w = 1'b1; alu_src_b = SRCB_FOUR; result_src = RES_ALU; pc_update = 1'b1; end
      S_DECODE: begin alu_src_a = SRCA_OLDPC; alu_src_b = SRCB_IMM; end
      S_MEMADR: begin alu_src_a = SRCA_RS1; alu_src_b = SRCB_IMM; end
      S_MEMREAD: adr_src = 1'b1;
      S_MEMWB: begin result_src = RES_DATA; reg_w = 1'b1; end
      S_MEMWRITE: begin adr_src = 1'b1; mem_w = 1'b1; end
      S_EXECR: begin alu_src_a = SRCA_RS1; alu_op = ALUOP_FUNCT; end
      S_EXECI: begin alu_src_a = SRCA_RS1; alu_src_b = SRCB_IMM; alu_op = ALUOP_FUNCT; end
      S_ALUWB: reg_w = 1'b1;
      S_BEQ: begin alu_src_a = SRCA_RS1; alu_op = ALUOP_SUB; branch = 1'b1; end
      S_JAL: begin alu_src_a = SRCA_OLDPC; alu_src_b = SRCB_FOUR; pc_update = 1'b1; end
      default: ;
    endcase
  end
  assign pc_write = ~reset & (pc_update | (branch & zero));
  assign ir_write = ~reset & ir_w;
  assign mem_write = ~reset & mem_w;
  assign reg_write = ~reset & reg_w;
  assign illegal_op = ~reset & (cur == S_DECODE) & ~legal;
  assign imm_src = (op == OP_LW || op == OP_I) ? IMM_I : op == OP_SW ? IMM_S :
                   op == OP_BEQ ? IMM_B : op == OP_JAL ? IMM_J : IMM_I;
  alu_decoder u_alu_decoder (
    .alu_op(alu_op),
    .funct3(funct3),
    .op5(op[5]),
    .funct7b5(funct7b5),
    .alu_control(alu_control)
  );
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: randomized scoreboard bench against a per-instruction phase model
module tb_multicycle_controller;
  logic clk = 1'b0, reset = 1'b1;
  logic [6:0] op = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic funct7b5 = 1'b0, zero = 1'b0;
  logic pc_write, adr_src, mem_write, ir_write, reg_write, illegal_op;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_control;
  int tests = 0, fails = 0;
  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RR = 7'b0110011;
  localparam logic [6:0] II = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111;
  typedef enum {P_RST, P_F, P_D, P_MA, P_MR, P_MWB, P_MWR, P_ER, P_EI, P_AWB, P_BQ, P_J} ph_e;
  typedef struct {logic [16:0] v; logic [16:0] m; string ph;} exp_t;
  exp_t q[$];
  exp_t cur;
  logic [16:0] act;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
    .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write), .ir_write(ir_write),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_control(alu_control), .imm_src(imm_src), .reg_write(reg_write), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  function automatic logic legal(logic [6:0] o);
    return o == LW || o == SW || o == RR || o == II || o == BQ || o == JL;
  endfunction

  function automatic logic [1:0] imm_of(logic [6:0] o);
    if (o == SW) return 2'd1;
    if (o == BQ) return 2'd2;
    if (o == JL) return 2'd3;
    return 2'd0;
  endfunction

  function automatic int alu_dec(logic is_r, logic [2:0] f3, logic f7);
    case (f3)
      3'b000: return (is_r && f7) ? 1 : 0;
      3'b010: return 5;
      3'b110: return 3;
      3'b111: return 2;
      default: return 0;
    endcase
  endfunction

  // negative select arguments mean "not checked in this phase"; write enables, imm_src, illegal_op always checked
  function automatic exp_t mk(ph_e p, logic pcw, logic mw, logic irw, logic rw, logic ill,
                              int adr, int res, int a, int b, int alu, logic [1:0] imm);
    exp_t e;
    e.ph = p.name();
    e.v = {pcw, 1'(adr), mw, irw, 2'(res), 2'(a), 2'(b), 3'(alu), imm, rw, ill};
    e.m = {1'b1, adr >= 0, 2'b11, {2{res >= 0}}, {2{a >= 0}}, {2{b >= 0}}, {3{alu >= 0}}, 4'b1111};
    return e;
  endfunction

  function automatic exp_t phase(ph_e p, logic [6:0] o, logic [2:0] f3, logic f7, logic z);
    logic [1:0] im;
    im = imm_of(o);
    case (p)
      P_RST: return mk(p, 0, 0, 0, 0, 0, 0, 2, 0, 2, 0, im);
      P_F:   return mk(p, 1, 0, 1, 0, 0, 0, 2, 0, 2, 0, im);
      P_D:   return mk(p, 0, 0, 0, 0, !legal(o), -1, -1, 1, 1, 0, im);
      P_MA:  return mk(p, 0, 0, 0, 0, 0, -1, -1, 2, 1, 0, im);
      P_MR:  return mk(p, 0, 0, 0, 0, 0, 1, 0, -1, -1, -1, im);
      P_MWB: return mk(p, 0, 0, 0, 1, 0, -1, 1, -1, -1, -1, im);
      P_MWR: return mk(p, 0, 1, 0, 0, 0, 1, 0, -1, -1, -1, im);
      P_ER:  return mk(p, 0, 0, 0, 0, 0, -1, -1, 2, 0, alu_dec(1'b1, f3, f7), im);
      P_EI:  return mk(p, 0, 0, 0, 0, 0, -1, -1, 2, 1, alu_dec(1'b0, f3, f7), im);
      P_AWB: return mk(p, 0, 0, 0, 1, 0, -1, 0, -1, -1, -1, im);
      P_BQ:  return mk(p, z, 0, 0, 0, 0, -1, 0, 2, 0, 1, im);
      default: return mk(p, 1, 0, 0, 0, 0, -1, 0, 1, 2, 0, im);
    endcase
  endfunction

  task automatic run_instr(logic [6:0] o, logic [2:0] f3, logic f7, int abort_at, int rst_cycles, int fz);
    ph_e seq[$];
    seq = {P_F, P_D};
    if (o == LW) seq = {seq, P_MA, P_MR, P_MWB};
    else if (o == SW) seq = {seq, P_MA, P_MWR};
    else if (o == RR) seq = {seq, P_ER, P_AWB};
    else if (o == II) seq = {seq, P_EI, P_AWB};
    else if (o == BQ) seq = {seq, P_BQ};
    else if (o == JL) seq = {seq, P_J, P_AWB};
    op = o;
    funct3 = f3;
    funct7b5 = f7;
    for (int i = 0; i < seq.size(); i++) begin
      if (i == abort_at) begin
        for (int k = 0; k < rst_cycles; k++) begin
          reset = 1'b1;
          zero = 1'($urandom);
          q.push_back(phase(P_RST, o, f3, f7, zero));
          @(posedge clk); #1;
        end
        reset = 1'b0;
        return;
      end
      zero = fz < 0 ? 1'($urandom) : 1'(fz);
      q.push_back(phase(seq[i], o, f3, f7, zero));
      @(posedge clk); #1;
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      cur = q.pop_front();
      act = {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b,
             alu_control, imm_src, reg_write, illegal_op};
      tests++;
      if ((act & cur.m) !== (cur.v & cur.m)) begin
        fails++;
        $display("FAIL %s at %0t: got %b want %b (mask %b)", cur.ph, $time, act, cur.v, cur.m);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic [6:0] ops [6];
    logic [6:0] o;
    int k, ab;
    ops = '{LW, SW, RR, II, BQ, JL};
    @(posedge clk); #1;
    reset = 1'b1;
    q.push_back(phase(P_RST, op, funct3, funct7b5, zero));
    @(posedge clk); #1;
    reset = 1'b0;
    run_instr(RR, 3'b000, 1'b1, 2, 2, -1);
    run_instr(LW, 3'b010, 1'b0, -1, 0, -1);
    run_instr(SW, 3'b010, 1'b0, -1, 0, -1);
    run_instr(RR, 3'b000, 1'b1, -1, 0, -1);
    run_instr(RR, 3'b010, 1'b0, -1, 0, -1);
    run_instr(RR, 3'b111, 1'b0, -1, 0, -1);
    run_instr(II, 3'b000, 1'b1, -1, 0, -1);
    run_instr(BQ, 3'b000, 1'b0, -1, 0, 1);
    run_instr(BQ, 3'b000, 1'b0, -1, 0, 0);
    run_instr(JL, 3'b000, 1'b0, -1, 0, -1);
    run_instr(7'b1111111, 3'b000, 1'b0, -1, 0, -1);
    run_instr(LW, 3'b010, 1'b0, 3, 1, -1);
    for (int n = 0; n < 300; n++) begin
      k = $urandom_range(0, 6);
      if (k == 6) begin
        o = 7'($urandom);
        while (legal(o)) o = 7'($urandom);
      end else o = ops[k];
      ab = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 4) : -1;
      run_instr(o, 3'($urandom), 1'($urandom), ab, $urandom_range(1, 2), -1);
    end
    repeat (2) @(posedge clk);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
